// File: rtl/k6502_seq.sv
// rtl/k6502_seq.sv - 6502 cycle/instruction sequencer: IR latch, one-hot cycle, RST/NMI/IRQ select
// Optional feature macro: K6502_SEQ_TRAP_EN (sticky trap on sequence overrun)
module k6502_seq #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic [7:0] din,
    input  logic       sync,
    input  logic       sr_i,
    input  logic       nmi_n,
    input  logic       irq_n,
    output logic [7:0] ir,
    output logic [5:0] cycle,
    output logic       rst_seq,
    output logic       nmi_seq,
    output logic       irq_seq,
    output logic       trap
);

    logic [SYNC_STAGES-1:0] nmi_sync;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                   nmi_s;
    logic                   irq_s;
    logic                   nmi_s_d;
    logic                   nmi_pend;
    logic                   nmi_fall;
    logic                   boundary;
    logic                   step;
    logic                   take_nmi;

    assign nmi_s    = nmi_sync[SYNC_STAGES-1];
    assign irq_s    = irq_sync[SYNC_STAGES-1];
    assign nmi_fall = nmi_s_d & ~nmi_s;
    assign take_nmi = boundary & nmi_pend;

`ifdef K6502_SEQ_TRAP_EN
    logic trap_q;
    logic overrun;

    assign trap     = trap_q;
    assign boundary = rdy & ~trap_q & sync;
    assign overrun  = rdy & ~trap_q & ~sync & cycle[5];
    assign step     = rdy & ~trap_q & ~sync & ~cycle[5];
`else
    // Running off the end of C_5 without SYNC is handled as if SYNC had been set.
    assign trap     = 1'b0;
    assign boundary = rdy & (sync | cycle[5]);
    assign step     = rdy & ~sync & ~cycle[5];
`endif

    // Synchronisers and the NMI edge detector run regardless of rdy or trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_sync <= '1;
            irq_sync <= '1;
            nmi_s_d  <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
            nmi_s_d  <= nmi_s;
            nmi_pend <= nmi_fall | (nmi_pend & ~take_nmi);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= 8'h00;
            cycle   <= 6'b000001;
            rst_seq <= 1'b1;
            nmi_seq <= 1'b0;
            irq_seq <= 1'b0;
`ifdef K6502_SEQ_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else if (boundary) begin
            cycle   <= 6'b000001;
            rst_seq <= 1'b0;
            if (nmi_pend) begin
                ir      <= 8'h00;
                nmi_seq <= 1'b1;
                irq_seq <= 1'b0;
            end else if (!irq_s && !sr_i) begin
                ir      <= 8'h00;
                nmi_seq <= 1'b0;
                irq_seq <= 1'b1;
            end else begin
                ir      <= din;
                nmi_seq <= 1'b0;
                irq_seq <= 1'b0;
            end
`ifdef K6502_SEQ_TRAP_EN
        end else if (overrun) begin
            cycle  <= 6'b000000;
            trap_q <= 1'b1;
`endif
        end else if (step) begin
            cycle <= cycle << 1;
        end
    end

endmodule
